// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
//   Four-requester round-robin arbiter for one shared datapath. A grant is held
//   for as long as its requester keeps req high. When the holder releases, the
//   next winner is found by scanning from a rotating priority pointer. All
//   outputs are registered, so there is no combinational path from req to gnt.
//
//   Handshake: req[i] is a level. Requester i raises it and keeps it high until
//   its work is done. gnt[i] is high for every cycle that i owns the resource.
//   Dropping req[i] releases the grant, and the new owner (or idle) appears at
//   the next rising edge.
//
// Parameters
//   MAX_HOLD   max consecutive cycles one grant may be held while others wait
//              (2..255). It only has an effect when RR_TIMEOUT_EN is defined.
//
// Configuration macro
//   RR_TIMEOUT_EN  when defined, a grant that has been held for MAX_HOLD cycles
//                  is taken away if any other requester is waiting.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   req        in   4  request vector, bit i = requester i
//   gnt        out  4  one-hot grant, 0000 when idle
//   gnt_idx    out  2  binary index of the current grant, 0 when idle
//   gnt_valid  out  1  high while any grant bit is high
// -----------------------------------------------------------------------------
module rr_arbiter_4 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter_4: MAX_HOLD must be in 2..255");
   end

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [1:0] idx_nxt;
   logic       valid_nxt;
   logic [3:0] gnt_nxt;
   logic       new_grant;
   logic       held;

   // Winner search: the first set req bit at ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   logic       win_found;
   logic [1:0] win_idx;

   always_comb begin
      logic [1:0] cand;
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      // The loop runs from the farthest candidate to the nearest, so the
      // candidate closest to ptr is the last one assigned and wins.
      for (int k = 3; k >= 0; k--) begin
         cand = ptr + 2'(k);
         if (req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Forced rotation after a long hold while someone else is waiting.
   logic timeout;

`ifdef RR_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

   logic [7:0] hold_cnt, hold_cnt_nxt;
   logic       others_waiting;

   assign others_waiting = |(req & ~gnt);
   assign timeout        = (hold_cnt == HOLD_LIM) && others_waiting;

   always_comb begin
      hold_cnt_nxt = hold_cnt;
      if (new_grant) begin
         hold_cnt_nxt = 8'd0;
      end else if (held && (hold_cnt != HOLD_LIM)) begin
         hold_cnt_nxt = hold_cnt + 8'd1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      idx_nxt   = gnt_idx;
      valid_nxt = gnt_valid;
      new_grant = 1'b0;
      held      = 1'b0;

      case (state)
         IDLE: begin
            if (win_found) begin
               new_grant = 1'b1;
            end
         end
         BUSY: begin
            if (req[gnt_idx] && !timeout) begin
               // No preemption: the holder keeps the grant.
               held = 1'b1;
            end else if (win_found) begin
               // Direct handoff with no idle cycle. The pointer already sits
               // one past the holder, so the holder has lowest priority here.
               new_grant = 1'b1;
            end else begin
               state_nxt = IDLE;
               valid_nxt = 1'b0;
               idx_nxt   = 2'd0;
            end
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            idx_nxt   = 2'd0;
         end
      endcase

      if (new_grant) begin
         state_nxt = BUSY;
         valid_nxt = 1'b1;
         idx_nxt   = win_idx;
         ptr_nxt   = win_idx + 2'd1;
      end

      gnt_nxt = valid_nxt ? (4'b0001 << idx_nxt) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         gnt       <= 4'b0000;
         gnt_idx   <= 2'd0;
         gnt_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         gnt       <= gnt_nxt;
         gnt_idx   <= idx_nxt;
         gnt_valid <= valid_nxt;
      end
   end

`ifdef RR_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= 8'd0;
      end else begin
         hold_cnt <= hold_cnt_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_4
//   Self-checking bench for rr_arbiter_4: a table of directed vectors, a
//   hand-written hold/timeout sequence, and random request traffic. The random
//   traffic is compared against a reference model that follows the arbitration
//   rules directly.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_4;

   localparam int MAX_HOLD = 8;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;

   always #5 clk = ~clk;

   rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   // ---------------- scoreboard ----------------
   int vectors     = 0;
   int miscompares = 0;
   logic [6:0] exp_q[$];   // {valid, idx, gnt}

   // Reference model state: current owner (-1 = none), pointer, hold length.
   int m_cur  = -1;
   int m_ptr  = 0;
   int m_hold = 0;

   function automatic int rr_pick(input int p, input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   function automatic bit timeout_enabled();
`ifdef RR_TIMEOUT_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_step(input logic r, input logic [3:0] q);
      int  w;
      bit  others;
      logic [6:0] e;
      if (r) begin
         m_cur = -1; m_ptr = 0; m_hold = 0;
      end else if (m_cur < 0) begin
         w = rr_pick(m_ptr, q);
         if (w >= 0) begin m_cur = w; m_ptr = (w + 1) % 4; m_hold = 0; end
      end else begin
         others = (q & ~(4'b0001 << m_cur)) != 4'b0000;
         if (q[m_cur] && !(timeout_enabled() && m_hold == MAX_HOLD - 1 && others)) begin
            if (m_hold < MAX_HOLD - 1) m_hold++;
         end else begin
            w = rr_pick(m_ptr, q);
            if (w >= 0) begin m_cur = w; m_ptr = (w + 1) % 4; m_hold = 0; end
            else m_cur = -1;
         end
      end
      if (m_cur < 0) e = 7'b0;
      else e = {1'b1, 2'(m_cur), 4'(4'b0001 << m_cur)};
      exp_q.push_back(e);
   endtask

   // ---------------- driver ----------------
   // Inputs change 1 time unit after a rising edge; outputs are sampled at the
   // same point, well away from the next active edge.
   task automatic drive_edge(input logic r, input logic [3:0] q);
      rst = r;
      req = q;
      @(posedge clk);
      model_step(r, q);
      #1;
   endtask

   task automatic report(input string name, input logic [6:0] got, input logic [6:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got valid=%b idx=%0d gnt=%b, want valid=%b idx=%0d gnt=%b",
                  name, got[6], got[5:4], got[3:0], exp[6], exp[5:4], exp[3:0]);
      end
   endtask

   task automatic check_model(input string name);
      logic [6:0] e;
      e = exp_q.pop_front();
      report(name, {gnt_valid, gnt_idx, gnt}, e);
   endtask

   task automatic check_const(input string name, input logic [3:0] eg,
                              input logic [1:0] ei, input logic ev);
      void'(exp_q.pop_front());
      report(name, {gnt_valid, gnt_idx, gnt}, {ev, ei, eg});
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      string      name;
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       valid;
   } vec_t;

   vec_t tbl[22];

   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish, want finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         run;
      bit         running;
      logic [3:0] cur_req;
      int         expect_run;

      rst = 1'b1;
      req = 4'b0000;

      //            name             rst   req      gnt      idx  valid
      tbl[0]  = '{"reset_a",        1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
      tbl[1]  = '{"reset_b",        1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
      tbl[2]  = '{"first_grant",    1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
      tbl[3]  = '{"release_idle",   1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[4]  = '{"single_req2",    1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[5]  = '{"single_rel",     1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[6]  = '{"reset_rot",      1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[7]  = '{"rot_0",          1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
      tbl[8]  = '{"rot_1",          1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1};
      tbl[9]  = '{"rot_2",          1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1};
      tbl[10] = '{"rot_3",          1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1};
      tbl[11] = '{"rot_wrap_0",     1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1};
      tbl[12] = '{"handoff_hold",   1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};
      tbl[13] = '{"handoff_direct", 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
      tbl[14] = '{"grant3",         1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
      tbl[15] = '{"rst_mid_grant",  1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0};
      tbl[16] = '{"regrant3",       1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
      tbl[17] = '{"hold3_no_preempt",1'b0,4'b1111, 4'b1000, 2'd3, 1'b1};
      tbl[18] = '{"ptr_wrap_to0",   1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1};
      tbl[19] = '{"idle_again",     1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[20] = '{"idle_req2",      1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[21] = '{"rel_and_new",    1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};

      for (int i = 0; i < 22; i++) begin
         drive_edge(tbl[i].rst, tbl[i].req);
         check_const(tbl[i].name, tbl[i].gnt, tbl[i].idx, tbl[i].valid);
      end

      // ---------------- long hold / timeout ----------------
      drive_edge(1'b1, 4'b0000);
      check_model("hold_reset");
      run     = 0;
      running = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive_edge(1'b0, 4'b0011);
         check_model("hold_seq");
         if (running && gnt == 4'b0001) run++;
         else running = 1'b0;
      end
      expect_run = timeout_enabled() ? MAX_HOLD : 100;
      vectors++;
      if (run != expect_run) begin
         miscompares++;
         $display("FAIL hold_length: got %0d cycles of gnt 0001, want %0d", run, expect_run);
      end

      // ---------------- random traffic ----------------
      drive_edge(1'b1, 4'b0000);
      check_model("rand_reset");
      cur_req = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0) cur_req = 4'($urandom_range(0, 15));
         drive_edge(($urandom_range(0, 59) == 0), cur_req);
         check_model("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
